// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared types and constants for the FSMC bus-side register target
package fsmc_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } fsmc_wb_state_t;

    // STATUS register bit positions.
    localparam int OVF_BIT   = 15;
    localparam int FULL_BIT  = 14;
    localparam int EMPTY_BIT = 13;
    localparam int CNT_MSB   = 12;

    // Word offsets of STATUS and the FIFO window above the control registers.
    localparam int STATUS_OFS = 0;
    localparam int FIFO_OFS   = 1;

endpackage

// File: rtl/fsmc_wb_regs_if.sv
// rtl/fsmc_wb_regs_if.sv - strobe/ack bus between the FSMC async slave and the register target
// Signals:
//   stb_i  access request (asynchronous level, held until ack_o seen)
//   we_i   1 = write, 0 = read
//   adr_i  word address, stable while stb_i high
//   dat_i  write data, stable while stb_i high
//   dat_o  registered read data
//   ack_o  4-phase acknowledge
interface fsmc_wb_regs_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16
) ();
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;

    modport master (output stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
    modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/fsmc_sync_fifo.sv
// rtl/fsmc_sync_fifo.sv - single-clock FIFO with wrap-bit pointers
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push, din      write strobe and data (ignored while full)
//   pop            read strobe (ignored while empty)
//   dout           head word, valid while not empty
//   full, empty    occupancy flags
//   count          number of stored words, 0..DEPTH
module fsmc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fsmc_wb_regs.sv
// rtl/fsmc_wb_regs.sv - bus-side register target: control regs, STATUS, FIFO write window
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   bus            strobe/ack bus (slave side)
//   regs_o         control registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fifo_dat_o     FIFO head word
//   fifo_valid_o   FIFO not empty
//   fifo_ready_i   fabric pop, taken when valid & ready
module fsmc_wb_regs
    import fsmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16,
    parameter int NREGS      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    fsmc_wb_regs_if.slave               bus,
    output logic [NREGS*DATA_WIDTH-1:0] regs_o,
    output logic [DATA_WIDTH-1:0]       fifo_dat_o,
    output logic                        fifo_valid_o,
    input  logic                        fifo_ready_i
);
    localparam int IW = $clog2(NREGS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] REGS_END   = ADDR_WIDTH'(NREGS);
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADR = ADDR_WIDTH'(NREGS + STATUS_OFS);
    localparam logic [ADDR_WIDTH-1:0] FIFO_ADR   = ADDR_WIDTH'(NREGS + FIFO_OFS);

    fsmc_wb_state_t                     state;
    logic                               stb_m;
    logic                               stb_s;
    logic [NREGS-1:0][DATA_WIDTH-1:0]   regs;
    logic                               ovf;
    logic [DATA_WIDTH-1:0]              dat_q;
    logic                               ack_q;
    logic                               is_reg;
    logic                               is_status;
    logic                               is_fifo;
    logic [DATA_WIDTH-1:0]              status;
    logic [DATA_WIDTH-1:0]              rdata;
    logic                               push;
    logic                               pop;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic [CW-1:0]                      fifo_count;

    assign regs_o       = regs;
    assign bus.dat_o    = dat_q;
    assign bus.ack_o    = ack_q;
    assign fifo_valid_o = !fifo_empty;

    assign is_reg    = (bus.adr_i < REGS_END);
    assign is_status = (bus.adr_i == STATUS_ADR);
    assign is_fifo   = (bus.adr_i == FIFO_ADR);

    // Push only in the single ACCESS cycle so a held strobe cannot push twice.
    assign push = (state == ACCESS) && bus.we_i && is_fifo;
    assign pop  = fifo_valid_o && fifo_ready_i;

    always_comb begin
        status            = '0;
        status[OVF_BIT]   = ovf;
        status[FULL_BIT]  = fifo_full;
        status[EMPTY_BIT] = fifo_empty;
        status[CNT_MSB:0] = (CNT_MSB + 1)'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        if (is_reg) begin
            rdata = regs[bus.adr_i[IW-1:0]];
        end else if (is_status) begin
            rdata = status;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            stb_m <= 1'b0;
            stb_s <= 1'b0;
            regs  <= '0;
            ovf   <= 1'b0;
            dat_q <= '0;
            ack_q <= 1'b0;
        end else begin
            stb_m <= bus.stb_i;
            stb_s <= stb_m;
            case (state)
                IDLE: begin
                    if (stb_s) state <= ACCESS;
                end
                ACCESS: begin
                    if (bus.we_i) begin
                        if (is_reg) regs[bus.adr_i[IW-1:0]] <= bus.dat_i;
                        if (is_status && bus.dat_i[OVF_BIT]) ovf <= 1'b0;
                        // The FIFO itself drops the word; only the sticky flag is kept here.
                        if (is_fifo && fifo_full) ovf <= 1'b1;
                    end else begin
                        dat_q <= rdata;
                    end
                    ack_q <= 1'b1;
                    state <= ACK;
                end
                ACK: begin
                    if (!stb_s) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fsmc_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .din   (bus.dat_i),
        .pop   (pop),
        .dout  (fifo_dat_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_fsmc_wb_regs.sv
// tb/tb_fsmc_wb_regs.sv - self-checking bench for fsmc_wb_regs
module tb_fsmc_wb_regs;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int NR = 8;
    localparam int FD = 16;
    localparam logic [AW-1:0] A_STATUS = AW'(NR);
    localparam logic [AW-1:0] A_FIFO   = AW'(NR + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*DW-1:0] regs_o;
    logic [DW-1:0]   fifo_dat_o;
    logic            fifo_valid_o;
    logic            fifo_ready_i;

    int checks = 0;
    int errors = 0;

    // Reference model: register array, FIFO contents queue, sticky overflow.
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_q [$];
    bit            m_ovf;

    fsmc_wb_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fsmc_wb_regs #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NREGS      (NR),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .regs_o       (regs_o),
        .fifo_dat_o   (fifo_dat_o),
        .fifo_valid_o (fifo_valid_o),
        .fifo_ready_i (fifo_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_status();
        logic [DW-1:0] s;
        s = 16'(m_q.size());
        if (m_ovf)            s = s + 16'h8000;
        if (m_q.size() == FD) s = s + 16'h4000;
        if (m_q.size() == 0)  s = s + 16'h2000;
        return s;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a < AW'(NR))  return m_regs[a[2:0]];
        if (a == A_STATUS) return model_status();
        return '0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (a < AW'(NR)) begin
            m_regs[a[2:0]] = d;
        end else if (a == A_STATUS) begin
            if (d[15]) m_ovf = 1'b0;
        end else if (a == A_FIFO) begin
            if (m_q.size() == FD) m_ovf = 1'b1;
            else m_q.push_back(d);
        end
    endfunction

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check(tag, 32'(regs_o[i*DW +: DW]), 32'(m_regs[i]));
        end
    endtask

    // Edges counted from the first edge that samples stb high until ack seen.
    task automatic wait_ack(input logic level, output int edges);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.ack_o !== level && n < 20);
        if (bus.ack_o !== level) check("ack_timeout", 32'(bus.ack_o), 32'(level));
        edges = n - 1;
    endtask

    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output int rise, output int fall);
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.we_i  = w;
        bus.adr_i = a;
        bus.dat_i = d;
        wait_ack(1'b1, rise);
        rd = bus.dat_o;
        bus.stb_i = 1'b0;
        wait_ack(1'b0, fall);
        if (w) model_write(a, d);
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] rd;
        int r, f;
        access(1'b1, a, d, rd, r, f);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] rd);
        int r, f;
        access(1'b0, a, '0, rd, r, f);
    endtask

    // Pop everything the model holds, checking head order on the way out.
    task automatic drain(input string tag);
        while (m_q.size() > 0) begin
            @(negedge clk);
            check({tag, "_valid"}, 32'(fifo_valid_o), 32'd1);
            check({tag, "_head"}, 32'(fifo_dat_o), 32'(m_q[0]));
            fifo_ready_i = 1'b1;
            @(posedge clk);
            void'(m_q.pop_front());
        end
        @(negedge clk);
        fifo_ready_i = 1'b0;
        check({tag, "_empty"}, 32'(fifo_valid_o), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        int            rise, fall, n;

        rst = 1'b1;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        fifo_ready_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ack_o), 32'd0);
        check("rst_dat", 32'(bus.dat_o), 32'd0);
        check("rst_valid", 32'(fifo_valid_o), 32'd0);
        check_regs("rst_regs");
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_ack", 32'(bus.ack_o), 32'd0);

        bus_read(A_STATUS, rd);
        check("status_after_reset", 32'(rd), 32'h2000);

        // Register write/read with handshake latency.
        access(1'b1, AW'(3), 16'hA5A5, rd, rise, fall);
        check("wr_ack_rise", 32'(rise), 32'd3);
        check("wr_ack_fall", 32'(fall), 32'd2);
        check("reg3_out", 32'(regs_o[3*DW +: DW]), 32'hA5A5);
        access(1'b0, AW'(3), '0, rd, rise, fall);
        check("reg3_read", 32'(rd), 32'hA5A5);
        check("rd_ack_rise", 32'(rise), 32'd3);
        check("rd_ack_fall", 32'(fall), 32'd2);

        // Fill past capacity.
        for (int i = 1; i <= 17; i++) bus_write(A_FIFO, 16'(i));
        bus_read(A_STATUS, rd);
        check("status_full_ovf", 32'(rd), 32'hC010);
        check("status_full_model", 32'(rd), 32'(model_status()));
        check("fifo_head_first", 32'(fifo_dat_o), 32'h0001);
        bus_read(A_FIFO, rd);
        check("fifo_window_read", 32'(rd), 32'h0000);
        check("fifo_no_pop", 32'(fifo_dat_o), 32'h0001);

        drain("drain16");
        bus_write(A_STATUS, 16'h8000);
        bus_read(A_STATUS, rd);
        check("status_cleared", 32'(rd), 32'h2000);

        // Push and pop on the same edge.
        bus_write(A_FIFO, 16'h1111);
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b1;
        bus.adr_i = A_FIFO;
        bus.dat_i = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        check("pp_pre_ack", 32'(bus.ack_o), 32'd0);
        fifo_ready_i = 1'b1;
        @(posedge clk);
        #1;
        fifo_ready_i = 1'b0;
        check("pp_ack", 32'(bus.ack_o), 32'd1);
        check("pp_head", 32'(fifo_dat_o), 32'h2222);
        check("pp_valid", 32'(fifo_valid_o), 32'd1);
        bus.stb_i = 1'b0;
        wait_ack(1'b0, fall);
        void'(m_q.pop_front());
        m_q.push_back(16'h2222);
        bus_read(A_STATUS, rd);
        check("pp_count", 32'(rd), 32'h0001);
        drain("pp_drain");

        // Randomised accesses against the model.
        for (int it = 0; it < 60; it++) begin
            n = int'($urandom_range(0, 11));
            if (n <= 9) a = AW'(n);
            else a = AW'($urandom_range(NR + 2, (1 << AW) - 1));
            d = 16'($urandom);
            w = 1'($urandom);
            if (w) begin
                bus_write(a, d);
            end else begin
                bus_read(a, rd);
                check("rand_read", 32'(rd), 32'(model_read(a)));
            end
            if (it % 20 == 19) drain("rand_drain");
        end
        check_regs("rand_regs");
        bus_read(A_STATUS, rd);
        check("rand_status", 32'(rd), 32'(model_status()));

        // Reset while in ACK with the strobe still held.
        bus_write(AW'(0), 16'h5A5A);
        @(negedge clk);
        bus.stb_i = 1'b1;
        bus.we_i  = 1'b0;
        bus.adr_i = AW'(19'h7FFFF);
        wait_ack(1'b1, rise);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_mid_ack", 32'(bus.ack_o), 32'd0);
        check_regs("rst_mid_regs");
        wait_ack(1'b1, rise);
        check("reack_latency", 32'(rise), 32'd3);
        check("reack_data", 32'(bus.dat_o), 32'h0000);
        bus.stb_i = 1'b0;
        wait_ack(1'b0, fall);
        bus_read(A_STATUS, rd);
        check("status_after_midrst", 32'(rd), 32'h2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
